// File: rtl/z_test_fifo.sv
// rtl/z_test_fifo.sv - pixel queue with in-order Z read matching and per-lane depth test
module z_test_fifo #(
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int PIXELS          = 2,
    parameter int Z_BITS          = 32,
    parameter int ADDR_BITS       = 29
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       z_active,
    input  logic [2:0]                 z_func,
    input  logic [63:0]                read_readdata,
    input  logic                       read_readdatavalid,
    input  logic                       enqueue,
    input  logic [ADDR_BITS-1:0]       color_address,
    input  logic [63:0]                color,
    input  logic [ADDR_BITS-1:0]       z_address,
    input  logic [63:0]                z,
    input  logic [PIXELS-1:0]          pixel_active,
    output logic [FIFO_DEPTH_LOG2:0]   size,
    output logic                       full,
    input  logic                       write_ready,
    output logic                       write_enqueue,
    output logic [ADDR_BITS-1:0]       write_color_address,
    output logic [63:0]                write_color,
    output logic [ADDR_BITS-1:0]       write_z_address,
    output logic [63:0]                write_z,
    output logic [PIXELS-1:0]          write_pixel_active,
    output logic                       overflow,
    output logic                       unexpected_z
);
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]              cnt_t;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Pixel queue storage, one array per field
    logic                 pq_za    [FIFO_DEPTH];
    logic [2:0]           pq_func  [FIFO_DEPTH];
    logic [PIXELS-1:0]    pq_pa    [FIFO_DEPTH];
    logic [63:0]          pq_z     [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] pq_zaddr [FIFO_DEPTH];
    logic [63:0]          pq_color [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] pq_caddr [FIFO_DEPTH];
    logic [63:0]          zq_data  [FIFO_DEPTH];

    ptr_t pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    ptr_t zq_wr_q, zq_wr_d, zq_rd_q, zq_rd_d;
    cnt_t size_q, size_d, za_count_q, za_count_d, zq_count_q, zq_count_d;
    logic overflow_q, overflow_d, unexpected_z_q, unexpected_z_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0] wr_caddr_q, wr_caddr_d, wr_zaddr_q, wr_zaddr_d;
    logic [63:0]          wr_color_q, wr_color_d, wr_z_q, wr_z_d;
    logic [PIXELS-1:0]    wr_pa_q, wr_pa_d;

    logic                 head_za;
    logic [2:0]           head_func;
    logic [PIXELS-1:0]    head_pa, lane_pass, pass_mask;
    logic [63:0]          head_z, zq_head;
    logic                 pq_empty, pq_full, zq_empty, zq_full, pending_zero;
    logic                 push, pop, z_push, z_pop;
    logic [Z_BITS-1:0]    lane_new, lane_old;

    always_comb begin
        head_za   = pq_za[pq_rd_q];
        head_func = pq_func[pq_rd_q];
        head_pa   = pq_pa[pq_rd_q];
        head_z    = pq_z[pq_rd_q];
        zq_head   = zq_data[zq_rd_q];
    end

    // Unsigned depth test of the head entry against the head Z word, lane by lane
    always_comb begin
        lane_pass = '0;
        lane_new  = '0;
        lane_old  = '0;
        for (int i = 0; i < PIXELS; i++) begin
            lane_new = head_z[i*Z_BITS +: Z_BITS];
            lane_old = zq_head[i*Z_BITS +: Z_BITS];
            case (head_func)
                3'd0:    lane_pass[i] = 1'b0;
                3'd1:    lane_pass[i] = lane_new <  lane_old;
                3'd2:    lane_pass[i] = lane_new == lane_old;
                3'd3:    lane_pass[i] = lane_new <= lane_old;
                3'd4:    lane_pass[i] = lane_new >  lane_old;
                3'd5:    lane_pass[i] = lane_new != lane_old;
                3'd6:    lane_pass[i] = lane_new >= lane_old;
                default: lane_pass[i] = 1'b1;
            endcase
            if (!head_za) begin
                lane_pass[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pq_empty     = (size_q == '0);
        pq_full      = (size_q == DEPTH_C);
        zq_empty     = (zq_count_q == '0);
        zq_full      = (zq_count_q == DEPTH_C);
        pending_zero = (za_count_q == zq_count_q);

        pop    = !pq_empty && write_ready && (!head_za || !zq_empty);
        push   = enqueue && !pq_full;
        z_push = read_readdatavalid && !pending_zero && !zq_full;
        z_pop  = pop && head_za;

        pq_wr_d    = push   ? next_ptr(pq_wr_q) : pq_wr_q;
        pq_rd_d    = pop    ? next_ptr(pq_rd_q) : pq_rd_q;
        zq_wr_d    = z_push ? next_ptr(zq_wr_q) : zq_wr_q;
        zq_rd_d    = z_pop  ? next_ptr(zq_rd_q) : zq_rd_q;
        size_d     = size_q + cnt_t'(push) - cnt_t'(pop);
        za_count_d = za_count_q + cnt_t'(push && z_active) - cnt_t'(z_pop);
        zq_count_d = zq_count_q + cnt_t'(z_push) - cnt_t'(z_pop);

        overflow_d     = overflow_q | (enqueue && pq_full)
                       | (read_readdatavalid && !pending_zero && zq_full);
        unexpected_z_d = unexpected_z_q | (read_readdatavalid && pending_zero);

        // Data outputs hold between pops; a zero mask retires the entry silently
        pass_mask  = head_pa & lane_pass;
        wr_en_d    = 1'b0;
        wr_caddr_d = wr_caddr_q;
        wr_color_d = wr_color_q;
        wr_zaddr_d = wr_zaddr_q;
        wr_z_d     = wr_z_q;
        wr_pa_d    = wr_pa_q;
        if (pop) begin
            wr_en_d    = |pass_mask;
            wr_caddr_d = pq_caddr[pq_rd_q];
            wr_color_d = pq_color[pq_rd_q];
            wr_zaddr_d = pq_zaddr[pq_rd_q];
            wr_z_d     = head_z;
            wr_pa_d    = pass_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pq_za[pq_wr_q]    <= z_active;
            pq_func[pq_wr_q]  <= z_func;
            pq_pa[pq_wr_q]    <= pixel_active;
            pq_z[pq_wr_q]     <= z;
            pq_zaddr[pq_wr_q] <= z_address;
            pq_color[pq_wr_q] <= color;
            pq_caddr[pq_wr_q] <= color_address;
        end
        if (z_push) begin
            zq_data[zq_wr_q] <= read_readdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pq_wr_q        <= '0;
            pq_rd_q        <= '0;
            zq_wr_q        <= '0;
            zq_rd_q        <= '0;
            size_q         <= '0;
            za_count_q     <= '0;
            zq_count_q     <= '0;
            overflow_q     <= 1'b0;
            unexpected_z_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_caddr_q     <= '0;
            wr_color_q     <= '0;
            wr_zaddr_q     <= '0;
            wr_z_q         <= '0;
            wr_pa_q        <= '0;
        end else begin
            pq_wr_q        <= pq_wr_d;
            pq_rd_q        <= pq_rd_d;
            zq_wr_q        <= zq_wr_d;
            zq_rd_q        <= zq_rd_d;
            size_q         <= size_d;
            za_count_q     <= za_count_d;
            zq_count_q     <= zq_count_d;
            overflow_q     <= overflow_d;
            unexpected_z_q <= unexpected_z_d;
            wr_en_q        <= wr_en_d;
            wr_caddr_q     <= wr_caddr_d;
            wr_color_q     <= wr_color_d;
            wr_zaddr_q     <= wr_zaddr_d;
            wr_z_q         <= wr_z_d;
            wr_pa_q        <= wr_pa_d;
        end
    end

    assign size                = size_q;
    assign full                = (size_q == DEPTH_C);
    assign write_enqueue       = wr_en_q;
    assign write_color_address = wr_caddr_q;
    assign write_color         = wr_color_q;
    assign write_z_address     = wr_zaddr_q;
    assign write_z             = wr_z_q;
    assign write_pixel_active  = wr_pa_q;
    assign overflow            = overflow_q;
    assign unexpected_z        = unexpected_z_q;
endmodule
